// File: rtl/fifoin_ddr_wr_pkg.sv
// -----------------------------------------------------------------------------
// fifoin_ddr_wr_pkg
//   Shared types and helpers for the fifoin -> DDR AXI4 burst writer.
//   No ports; imported by fifoin_ddr_wr and fifoin_ddr_wr_prefetch.
// -----------------------------------------------------------------------------
package fifoin_ddr_wr_pkg;

  // Write-path FSM: address phase, data phase, response phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_e;

  // Counter width for beats/reads in one burst; holds 0..64 inclusive.
  localparam int CNT_W = 7;

  // Bytes carried by one AXI data beat.
  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/fifoin_ddr_wr_prefetch.sv
// -----------------------------------------------------------------------------
// fifoin_ddr_wr_prefetch
//   Two-entry in-order buffer between the FIFO read port and the AXI W channel.
//   Entry 0 is always the head, so head_o can drive wdata directly.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i         write push_data_i (the FIFO word returned 1 clk after rd_en)
//   push_data_i    FIFO read data
//   pop_i          consume the head (wvalid && wready); only asserted when valid_o
//   head_o         oldest stored word
//   valid_o        buffer non-empty
//   occupancy_o    number of stored words (0..2)
// -----------------------------------------------------------------------------
module fifoin_ddr_wr_prefetch
  import fifoin_ddr_wr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic [1:0]            occupancy_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            occ_q,  occ_d;

  // NOTE: every variable written here gets its current value first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; new word lands behind the head.
        if (occ_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the data entries are reset as well because entry 0 drives wdata
  // straight out of the block, which must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o      = ent0_q;
  assign valid_o     = (occ_q != 2'd0);
  assign occupancy_o = occ_q;

endmodule

// File: rtl/fifoin_ddr_wr.sv
// -----------------------------------------------------------------------------
// fifoin_ddr_wr
//   Drains the fifoin read side and writes it to DDR as fixed-length AXI4 INCR
//   bursts at linear frame addresses starting at BASE_ADDR, wrapping at frame
//   end and pulsing frame_done when the last burst of a frame is acknowledged.
// Ports
//   clk, rst_n                      DDR user clock, async active-low reset
//   frame_start                     restart addressing at BASE_ADDR (applied in IDLE)
//   fifo_rd_en / fifo_rd_data       FIFO read strobe / data (1 clk latency)
//   fifo_rd_empty, fifo_rd_water_level  FIFO status
//   axi_aw*, axi_w*, axi_b*         AXI4 write address/data/response channels
//   frame_done                      1-clk pulse after the final burst of a frame
//   busy                            FSM not in IDLE
// -----------------------------------------------------------------------------
module fifoin_ddr_wr
  import fifoin_ddr_wr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned LEVEL_WIDTH = 8,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_BYTES = 1843200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0]  fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int unsigned BURST_BYTES = BURST_LEN * beat_bytes(DATA_WIDTH);

  localparam logic [ADDR_WIDTH-1:0]  BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0]  BURST_A   = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0]  END_A     = ADDR_WIDTH'(BASE_ADDR + FRAME_BYTES);
  localparam logic [CNT_W-1:0]       BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(BURST_LEN - 1);
  localparam logic [LEVEL_WIDTH-1:0] START_LVL = LEVEL_WIDTH'(BURST_LEN);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    fs_pend_q, fs_pend_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;     // reads issued this burst
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d; // beats accepted this burst
  logic                    rd_pend_q;              // read issued last clk, data arrives now
  logic                    frame_done_q, frame_done_d;

  logic                    buf_valid;
  logic [1:0]              buf_occ;
  logic [DATA_WIDTH-1:0]   buf_head;
  logic                    pop;
  logic                    last_pop;
  logic [2:0]              slots_used;

  fifoin_ddr_wr_prefetch #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prefetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_pend_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .head_o      (buf_head),
    .valid_o     (buf_valid),
    .occupancy_o (buf_occ)
  );

  assign pop      = buf_valid && axi_wready;
  assign last_pop = pop && (beat_cnt_q == LAST_CNT);

  // A slot freed by this clk's pop counts as free, which keeps one beat per
  // clk flowing once the pipeline has filled. pop implies occupancy >= 1.
  assign slots_used = {1'b0, buf_occ} + {2'b00, rd_pend_q} - {2'b00, pop};

  assign fifo_rd_en = ((state_q == ST_AW) || (state_q == ST_W)) &&
                      (slots_used < 3'd2) &&
                      (rd_cnt_q < BURST_CNT) &&
                      !fifo_rd_empty;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fs_pend_d    = fs_pend_q | frame_start;
    rd_cnt_d     = rd_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;

    if (fifo_rd_en) rd_cnt_d   = rd_cnt_q + 1'b1;
    if (pop)        beat_cnt_d = beat_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fs_pend_d) begin
          addr_d    = BASE_A;
          fs_pend_d = 1'b0;
        end
        if (fifo_rd_water_level >= START_LVL) begin
          state_d    = ST_AW;
          rd_cnt_d   = '0;
          beat_cnt_d = '0;
        end
      end
      ST_AW: begin
        // Data may run ahead of the address handshake; if every beat already
        // went out, skip straight to the response phase.
        if (axi_awready) begin
          if (last_pop || (beat_cnt_q == BURST_CNT)) state_d = ST_B;
          else                                       state_d = ST_W;
        end
      end
      ST_W: begin
        if (last_pop) state_d = ST_B;
      end
      ST_B: begin
        if (axi_bvalid) begin
          if (addr_q + BURST_A == END_A) begin
            addr_d       = BASE_A;
            frame_done_d = 1'b1;
          end else begin
            addr_d = addr_q + BURST_A;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= BASE_A;
      fs_pend_q    <= 1'b0;
      rd_cnt_q     <= '0;
      beat_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fs_pend_q    <= fs_pend_d;
      rd_cnt_q     <= rd_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_pend_q    <= fifo_rd_en;
      frame_done_q <= frame_done_d;
    end
  end

  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'(BURST_LEN - 1);
  assign axi_awvalid = (state_q == ST_AW);
  assign axi_wdata   = buf_head;
  assign axi_wstrb   = '1;
  assign axi_wvalid  = buf_valid;
  assign axi_wlast   = buf_valid && (beat_cnt_q == LAST_CNT);
  assign axi_bready  = (state_q == ST_B);
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifoin_ddr_wr.sv
// -----------------------------------------------------------------------------
// tb_fifoin_ddr_wr
//   Directed bench for fifoin_ddr_wr with a 512-byte burst and 2048-byte frame.
//   A table of burst records drives awready/wready/frame_start patterns and
//   gives the expected address and frame_done; reset cases are hand-written.
// -----------------------------------------------------------------------------
module tb_fifoin_ddr_wr;

  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic         fifo_rd_en;
  logic [255:0] fifo_rd_data;
  logic         fifo_rd_empty;
  logic [7:0]   fifo_rd_water_level;
  logic [27:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic         axi_bvalid;
  logic         axi_bready;
  logic         frame_done;
  logic         busy;

  fifoin_ddr_wr #(
    .DATA_WIDTH  (256),
    .ADDR_WIDTH  (28),
    .LEVEL_WIDTH (8),
    .BURST_LEN   (16),
    .BASE_ADDR   (0),
    .FRAME_BYTES (2048)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_start         (frame_start),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .axi_awaddr          (axi_awaddr),
    .axi_awlen           (axi_awlen),
    .axi_awvalid         (axi_awvalid),
    .axi_awready         (axi_awready),
    .axi_wdata           (axi_wdata),
    .axi_wstrb           (axi_wstrb),
    .axi_wlast           (axi_wlast),
    .axi_wvalid          (axi_wvalid),
    .axi_wready          (axi_wready),
    .axi_bvalid          (axi_bvalid),
    .axi_bready          (axi_bready),
    .frame_done          (frame_done),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          aw_delay;  // clks awready is held low once awvalid is seen
    bit          wr_rand;   // wready random 50% instead of constant 1
    bit          fs_mid;    // pulse frame_start after beat 7
    logic [27:0] exp_addr;
    bit          exp_done;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO / W-channel model state.
  int           next_word = 0;  // value of the next word the FIFO returns
  int           exp_word  = 0;  // value the next accepted beat must carry
  int           beats     = 0;  // beats accepted in current burst
  int           rds       = 0;  // rd_en strobes in current burst
  bit           hold_pending = 0;
  logic [255:0] held_data;
  bit           b_done;

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: observe outputs mid-cycle, then update the FIFO/B models just
  // after the rising edge (inputs change at posedge+1).
  task automatic tick();
    logic         s_rd, s_beat, s_hold, s_b, s_wlast;
    logic [255:0] s_wdata;
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_beat  = axi_wvalid && axi_wready;
    s_hold  = axi_wvalid && !axi_wready;
    s_b     = axi_bvalid && axi_bready;
    s_wdata = axi_wdata;
    s_wlast = axi_wlast;
    check("outstanding_le2", ((rds - beats) <= 2), 1'b1);
    if (hold_pending) check("w_stable", {axi_wvalid, axi_wdata}, {1'b1, held_data});
    hold_pending = s_hold;
    held_data    = s_wdata;
    if (s_beat) begin
      check("wdata", s_wdata, {8{exp_word}});
      check("wlast", s_wlast, (beats == BL - 1));
      exp_word++;
      beats++;
    end
    if (s_rd) rds++;
    @(posedge clk);
    #1;
    if (s_rd) begin
      fifo_rd_data = {8{next_word}};
      next_word++;
    end
    if (s_b) begin
      axi_bvalid = 1'b0;
      b_done     = 1'b1;
    end
  endtask

  task automatic run_burst(input vec_t v);
    int cyc    = 0;
    bit aw_seen = 0;
    int aw_cyc = 0;
    bit fs_sent = 0;
    beats = 0;
    rds   = 0;
    b_done = 0;
    axi_awready = 1'b0;
    fifo_rd_water_level = 8'd16;
    while (!b_done && cyc < 400) begin
      if (axi_awvalid) begin
        check("awaddr", axi_awaddr, v.exp_addr);
        if (!aw_seen) begin
          aw_seen = 1;
          aw_cyc  = cyc;
          check("awlen", axi_awlen, 8'd15);
        end
      end
      axi_awready = axi_awvalid && ((cyc - aw_cyc) >= v.aw_delay);
      axi_wready  = v.wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beats == BL && !axi_bvalid) axi_bvalid = 1'b1;
      frame_start = v.fs_mid && (beats == 7) && !fs_sent;
      if (frame_start) fs_sent = 1;
      tick();
      cyc++;
    end
    frame_start = 1'b0;
    check("b_handshake_in_time", b_done, 1'b1);
    check("frame_done", frame_done, v.exp_done);
    check("beats_per_burst", beats, BL);
    check("rd_en_per_burst", rds, BL);
    tick();
    check("frame_done_one_clk", frame_done, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {fifo_rd_en, axi_awvalid, axi_wvalid, axi_wlast,
                            axi_bready, frame_done, busy}, 7'd0);
    check({tag, "_awaddr"}, axi_awaddr, 28'd0);
    check({tag, "_awlen"},  axi_awlen, 8'd15);
    check({tag, "_wstrb"},  axi_wstrb, 32'hFFFF_FFFF);
    check({tag, "_wdata"},  axi_wdata, 256'd0);
  endtask

  initial begin
    int aw_cnt;
    vecs[0] = '{0, 1'b0, 1'b0, 28'd0,    1'b0};  // full-rate burst, data 0..15
    vecs[1] = '{5, 1'b1, 1'b0, 28'd512,  1'b0};  // random wready, late awready
    vecs[2] = '{0, 1'b0, 1'b1, 28'd1024, 1'b0};  // frame_start mid-burst
    vecs[3] = '{0, 1'b0, 1'b0, 28'd0,    1'b0};  // restarted at base
    vecs[4] = '{2, 1'b1, 1'b0, 28'd512,  1'b0};
    vecs[5] = '{0, 1'b0, 1'b0, 28'd1024, 1'b0};
    vecs[6] = '{1, 1'b0, 1'b0, 28'd1536, 1'b1};  // last burst of frame
    vecs[7] = '{0, 1'b0, 1'b0, 28'd0,    1'b0};  // wrapped to base

    rst_n = 1'b0;
    frame_start = 1'b0;
    fifo_rd_data = '0;
    fifo_rd_empty = 1'b0;
    fifo_rd_water_level = 8'd0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Level one short of a burst: nothing may start.
    fifo_rd_water_level = 8'd15;
    aw_cnt = 0;
    rds = 0;
    beats = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (axi_awvalid) aw_cnt++;
    end
    check("no_aw_at_level15", aw_cnt, 0);
    check("no_rd_at_level15", rds, 0);

    fifo_rd_water_level = 8'd16;
    tick();
    check("aw_next_clk_at_level16", axi_awvalid, 1'b1);

    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // Reset in the middle of the data phase.
    fifo_rd_water_level = 8'd16;
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    beats = 0;
    rds   = 0;
    for (int i = 0; i < 60 && beats < 7; i++) tick();
    check("reached_beat7", beats, 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    fifo_rd_water_level = 8'd15;
    axi_bvalid = 1'b0;
    hold_pending = 0;
    next_word = 100;
    exp_word  = 100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats = 0;
    rds   = 0;
    aw_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (axi_awvalid) aw_cnt++;
    end
    check("post_reset_no_rd", rds, 0);
    check("post_reset_no_aw", aw_cnt, 0);
    run_burst('{0, 1'b0, 1'b0, 28'd0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
